// File: rtl/store_trace_unit_if.sv
// store_trace_unit_if: cpu store strobe inputs and trace drain port of the store trace unit
interface store_trace_unit_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  modport master (
    output MemWrite, ALUResult, WriteData, trace_ready,
    input  trace_valid, trace_addr, trace_data
  );
  modport slave (
    input  MemWrite, ALUResult, WriteData, trace_ready,
    output trace_valid, trace_addr, trace_data
  );
endinterface

// File: rtl/store_trace_unit.sv
// store_trace_unit: traces cpu stores into a FWFT FIFO and reports tohost pass/fail or timeout
module store_trace_unit #(
  parameter int          DEPTH          = 8,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FFC,
  parameter int          TIMEOUT_CYCLES = 50,
  parameter int          CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  store_trace_unit_if.slave    bus,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [30:0]          fail_code,
  output logic                 overflow,
  output logic [CNT_W-1:0]     store_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, HALT_PASS, HALT_FAIL, TIMEOUT} state_t;
  state_t state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [63:0] mem [DEPTH];
  logic [CNT_W-1:0] cyc;
  logic in_run, tohost, empty, full, pop, push_req, push, timeout_hit;
  assign in_run      = state == RUN;
  assign tohost      = bus.MemWrite && bus.ALUResult == TOHOST_ADDR;
  assign empty       = wr_ptr == rd_ptr;
  assign full        = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign pop         = !empty && bus.trace_ready;
  assign push_req    = in_run && bus.MemWrite && !tohost;
  // a simultaneous pop frees the head slot, so a full FIFO still accepts the push
  assign push        = push_req && (!full || pop);
  assign timeout_hit = TIMEOUT_CYCLES != 0 && cyc == CNT_W'(TIMEOUT_CYCLES - 1);
  assign bus.trace_valid = !empty;
  assign {bus.trace_addr, bus.trace_data} = empty ? 64'd0 : mem[rd_ptr[AW-1:0]];
  assign done = !in_run;
  assign pass = state == HALT_PASS;
  assign fail = state == HALT_FAIL || state == TIMEOUT;
  always_comb begin
    state_nx = state;
    if (in_run)
      state_nx = tohost ? (bus.WriteData == 32'd1 ? HALT_PASS : HALT_FAIL)
               : timeout_hit ? TIMEOUT : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      store_count <= '0;
      cyc         <= '0;
      fail_code   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
      if (push_req && ~&store_count) store_count <= store_count + 1'b1;
      if (in_run) cyc <= cyc + 1'b1;
      if (in_run && tohost && bus.WriteData != 32'd1) fail_code <= bus.WriteData[31:1];
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.ALUResult, bus.WriteData};
endmodule

// File: tb/tb_store_trace_unit.sv
// tb_store_trace_unit: directed self-checking bench for store_trace_unit
module tb_store_trace_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done, pass, fail, overflow;
  logic [30:0] fail_code;
  logic [15:0] store_count;
  int n_chk = 0;
  int n_fail = 0;
  store_trace_unit_if bus ();
  store_trace_unit dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .overflow(overflow), .store_count(store_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bus.MemWrite  = mw;
    bus.ALUResult = a;
    bus.WriteData = d;
    bus.trace_ready = rdy;
  endtask
  task automatic do_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    // T1: two stores stream straight through
    do_reset();
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(store_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_addr", 64'(bus.trace_addr), 64'd0);
    drive(1'b1, 32'h10, 32'd5, 1'b1);
    step();
    chk("t1_valid0", 64'(bus.trace_valid), 64'd1);
    chk("t1_rec0", {bus.trace_addr, bus.trace_data}, {32'h10, 32'd5});
    drive(1'b1, 32'h14, 32'd7, 1'b1);
    step();
    chk("t1_valid1", 64'(bus.trace_valid), 64'd1);
    chk("t1_rec1", {bus.trace_addr, bus.trace_data}, {32'h14, 32'd7});
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    chk("t1_empty", 64'(bus.trace_valid), 64'd0);
    chk("t1_count", 64'(store_count), 64'd2);
    // T2: ten stores into an eight-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b0);
      step();
      if (i == 7) chk("t2_no_ovf_at_full", 64'(overflow), 64'd0);
    end
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_count", 64'(store_count), 64'd10);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", {31'd0, bus.trace_valid, bus.trace_addr, bus.trace_data},
          {31'd0, 1'b1, 32'h100 + 32'(4 * i), 32'(i)});
      step();
    end
    chk("t2_empty", 64'(bus.trace_valid), 64'd0);
    chk("t2_ovf_sticky", 64'(overflow), 64'd1);
    // T3: push and pop on the same edge while full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h10 + 32'(i), 1'b0);
      step();
    end
    drive(1'b1, 32'h300, 32'hAA, 1'b1);
    step();
    chk("t3_no_overflow", 64'(overflow), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", {bus.trace_addr, bus.trace_data},
          i < 7 ? {32'h204 + 32'(4 * i), 32'h11 + 32'(i)} : {32'h300, 32'hAA});
      step();
    end
    chk("t3_empty", 64'(bus.trace_valid), 64'd0);
    // T4: passing tohost store freezes further tracing
    do_reset();
    drive(1'b1, 32'h40, 32'd9, 1'b1);
    step();
    drive(1'b1, 32'hFFC, 32'd1, 1'b1);
    step();
    chk("t4_flags", {61'd0, pass, fail, done}, {61'd0, 3'b101});
    chk("t4_tohost_not_pushed", 64'(bus.trace_valid), 64'd0);
    drive(1'b1, 32'h44, 32'd3, 1'b1);
    step();
    chk("t4_ignored_push", 64'(bus.trace_valid), 64'd0);
    chk("t4_count_frozen", 64'(store_count), 64'd1);
    chk("t4_still_pass", 64'(pass), 64'd1);
    // T5: failing tohost store
    do_reset();
    drive(1'b1, 32'hFFC, 32'h2B, 1'b1);
    step();
    chk("t5_fail_flags", {61'd0, pass, fail, done}, {61'd0, 3'b011});
    chk("t5_fail_code", 64'(fail_code), 64'h15);
    chk("t5_count", 64'(store_count), 64'd0);
    // T5: timeout after 50 RUN cycles
    do_reset();
    repeat (49) step();
    chk("t5_no_timeout_49", 64'(done), 64'd0);
    step();
    chk("t5_timeout_flags", {61'd0, pass, fail, done}, {61'd0, 3'b011});
    chk("t5_timeout_code", 64'(fail_code), 64'd0);
    // tohost on the timeout edge takes priority
    do_reset();
    repeat (49) step();
    drive(1'b1, 32'hFFC, 32'd1, 1'b0);
    step();
    chk("t5_tohost_wins", {61'd0, pass, fail, done}, {61'd0, 3'b101});
    // T6: async reset mid-drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 32'(i), 1'b0);
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    repeat (4) step();
    drive(1'b1, 32'hFFC, 32'd1, 1'b1);
    step();
    chk("t6_halt_drains", {bus.trace_addr, bus.trace_data}, {32'h514, 32'd5});
    chk("t6_pre_state", {60'd0, bus.trace_valid, overflow, done, pass}, {60'd0, 4'b1111});
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_clear", {60'd0, bus.trace_valid, overflow, done, pass}, 64'd0);
    chk("t6_count_clear", 64'(store_count), 64'd0);
    chk("t6_addr_clear", {bus.trace_addr, bus.trace_data}, 64'd0);
    step();
    #1 rst = 1'b0;
    step();
    chk("t6_after_release", {60'd0, bus.trace_valid, overflow, done, fail}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
